// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset sequencer.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_MEM,
    BRANCH,
    TRAP
  } state_t;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_BEQ = 7'd99;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_RF  = 2'd2;
  localparam logic [1:0] ALU_IF  = 2'd3;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory stall cycles; flags timeout on the last one.
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (req && ready) begin
      count <= '0;
    end else if (req) begin
      count <= count + 1'b1;
    end
  end

  // A ready in the final stall cycle still completes the transfer.
  assign timeout = (TIMEOUT != 0) && req && !ready
                   && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM over a shared instruction/data memory.
// Optional perf counters build with PERF_COUNTERS_EN.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t     state, state_n;
  logic       trap_q;
  logic [1:0] cause_q, cause_n;
  logic       timeout;

  mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .req    (mem_req),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state <= state_n;
      if (state_n == TRAP && state != TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_n;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cause_n    = CAUSE_NONE;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            alu_src_b = SRC_B_FOUR;
            state_n   = DECODE;
          end else if (timeout) begin
            state_n = TRAP;
            cause_n = CAUSE_TIMEOUT;
          end
        end
        DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          if (opcode == OP_R) state_n = EXEC_R;
          else if (opcode == OP_I) state_n = EXEC_I;
          else if (opcode == OP_LW || opcode == OP_SW) state_n = ADDR;
          else if (opcode == OP_BEQ) state_n = BRANCH;
          else begin
            state_n = TRAP;
            cause_n = CAUSE_ILLEGAL;
          end
        end
        EXEC_R: begin
          alu_src_a = SRC_A_REG;
          alu_op    = ALU_RF;
          state_n   = WB_ALU;
        end
        EXEC_I: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_IF;
          state_n   = WB_ALU;
        end
        ADDR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          state_n   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_n = WB_MEM;
          else if (timeout) begin
            state_n = TRAP;
            cause_n = CAUSE_TIMEOUT;
          end
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_n = FETCH;
          end else if (timeout) begin
            state_n = TRAP;
            cause_n = CAUSE_TIMEOUT;
          end
        end
        WB_ALU: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_n   = FETCH;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_n    = FETCH;
        end
        BRANCH: begin
          alu_src_a = SRC_A_REG;
          alu_op    = ALU_SUB;
          pc_src    = 1'b1;
          pc_en     = zero;
          retire    = 1'b1;
          state_n   = FETCH;
        end
        TRAP: state_n = TRAP;
        default: state_n = FETCH;
      endcase
    end
  end

  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? CAUSE_NONE : cause_q;

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4).
// Counter checks compile in only with PERF_COUNTERS_EN.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_en, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, retire, trap;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;

  int checks   = 0;
  int failures = 0;

  multicycle_control #(
    .MEM_TIMEOUT(4),
    .CNT_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src,
                alu_src_a, alu_src_b, alu_op,
                reg_write, mem_to_reg, retire, trap, trap_cause};

  function automatic logic [17:0] mk(
    input logic req, we, io, irw, pce, pcs,
    input logic [1:0] a, b, op,
    input logic rw, m2r, ret, tr,
    input logic [1:0] tc);
    return {req, we, io, irw, pce, pcs, a, b, op, rw, m2r, ret, tr, tc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic rdy,
                      input logic [6:0] op, input logic z,
                      input logic [17:0] e);
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    #1;
    chk(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("reset_outputs_zero", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [17:0] v_zero, v_fr, v_fw, v_dec, v_er, v_ei, v_addr;
  logic [17:0] v_mrd, v_mw, v_mwr, v_wba, v_wbm, v_br1, v_br0;
  logic [17:0] v_trap_ill, v_trap_to;

  initial begin
    v_zero     = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,0,2'd0);
    v_fr       = mk(1,0,0,1,1,0,2'd0,2'd1,2'd0,0,0,0,0,2'd0);
    v_fw       = mk(1,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,0,2'd0);
    v_dec      = mk(0,0,0,0,0,0,2'd2,2'd2,2'd0,0,0,0,0,2'd0);
    v_er       = mk(0,0,0,0,0,0,2'd1,2'd0,2'd2,0,0,0,0,2'd0);
    v_ei       = mk(0,0,0,0,0,0,2'd1,2'd2,2'd3,0,0,0,0,2'd0);
    v_addr     = mk(0,0,0,0,0,0,2'd1,2'd2,2'd0,0,0,0,0,2'd0);
    v_mrd      = mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,0,0,0,0,2'd0);
    v_mw       = mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,0,0,0,0,2'd0);
    v_mwr      = mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,0,0,1,0,2'd0);
    v_wba      = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,1,0,1,0,2'd0);
    v_wbm      = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,1,1,1,0,2'd0);
    v_br1      = mk(0,0,0,0,1,1,2'd1,2'd0,2'd1,0,0,1,0,2'd0);
    v_br0      = mk(0,0,0,0,0,1,2'd1,2'd0,2'd1,0,0,1,0,2'd0);
    v_trap_ill = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,1,2'd1);
    v_trap_to  = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,0,0,1,2'd2);

    opcode = 7'd0;
    zero   = 1'b0;
    do_reset();
`ifdef PERF_COUNTERS_EN
    chk("cycle_cnt_reset", cycle_cnt, 32'd0);
    chk("instret_cnt_reset", instret_cnt, 32'd0);
`endif

    // R-type, no waits
    step("r_fetch", 1, 7'd51, 0, v_fr);
    step("r_decode", 1, 7'd51, 0, v_dec);
    step("r_exec", 1, 7'd51, 0, v_er);
    step("r_wb", 1, 7'd51, 0, v_wba);
`ifdef PERF_COUNTERS_EN
    chk("r_instret", instret_cnt, 32'd1);
    chk("r_cycles", cycle_cnt, 32'd4);
`endif

    // I-type
    step("i_fetch", 1, 7'd19, 0, v_fr);
    step("i_decode", 1, 7'd19, 0, v_dec);
    step("i_exec", 1, 7'd19, 0, v_ei);
    step("i_wb", 1, 7'd19, 0, v_wba);

    // lw with two stalls in FETCH and in MEM_RD
    step("lw_fetch_w1", 0, 7'd3, 0, v_fw);
    step("lw_fetch_w2", 0, 7'd3, 0, v_fw);
    step("lw_fetch", 1, 7'd3, 0, v_fr);
    step("lw_decode", 1, 7'd3, 0, v_dec);
    step("lw_addr", 1, 7'd3, 0, v_addr);
    step("lw_mrd_w1", 0, 7'd3, 0, v_mrd);
    step("lw_mrd_w2", 0, 7'd3, 0, v_mrd);
    step("lw_mrd", 1, 7'd3, 0, v_mrd);
    step("lw_wb", 1, 7'd3, 0, v_wbm);

    // sw
    step("sw_fetch", 1, 7'd35, 0, v_fr);
    step("sw_decode", 1, 7'd35, 0, v_dec);
    step("sw_addr", 1, 7'd35, 0, v_addr);
    step("sw_mwr", 1, 7'd35, 0, v_mwr);

    // beq taken and not taken
    step("beq1_fetch", 1, 7'd99, 1, v_fr);
    step("beq1_decode", 1, 7'd99, 1, v_dec);
    step("beq1_branch", 1, 7'd99, 1, v_br1);
    step("beq0_fetch", 1, 7'd99, 0, v_fr);
    step("beq0_decode", 1, 7'd99, 0, v_dec);
    step("beq0_branch", 1, 7'd99, 0, v_br0);
`ifdef PERF_COUNTERS_EN
    chk("instret_after_6", instret_cnt, 32'd6);
`endif

    // illegal opcode
    step("ill_fetch", 1, 7'h7f, 0, v_fr);
    step("ill_decode", 1, 7'h7f, 0, v_dec);
    step("ill_trap", 1, 7'h7f, 0, v_trap_ill);
    step("ill_trap_hold", 1, 7'd51, 0, v_trap_ill);
    step("ill_trap_hold2", 1, 7'd51, 0, v_trap_ill);

    // timeout after four stalled FETCH cycles
    do_reset();
    step("to_w1", 0, 7'd51, 0, v_fw);
    step("to_w2", 0, 7'd51, 0, v_fw);
    step("to_w3", 0, 7'd51, 0, v_fw);
    step("to_w4", 0, 7'd51, 0, v_fw);
    step("to_trap", 1, 7'd51, 0, v_trap_to);
    step("to_trap_hold", 1, 7'd51, 0, v_trap_to);

    // ready on the fourth request cycle wins
    do_reset();
    step("nt_w1", 0, 7'd51, 0, v_fw);
    step("nt_w2", 0, 7'd51, 0, v_fw);
    step("nt_w3", 0, 7'd51, 0, v_fw);
    step("nt_fetch", 1, 7'd51, 0, v_fr);
    step("nt_decode", 1, 7'd51, 0, v_dec);
    step("nt_exec", 1, 7'd51, 0, v_er);
    step("nt_wb", 1, 7'd51, 0, v_wba);

    // reset during a stalled store
    step("rs_fetch", 1, 7'd35, 0, v_fr);
    step("rs_decode", 1, 7'd35, 0, v_dec);
    step("rs_addr", 1, 7'd35, 0, v_addr);
    step("rs_mw_wait", 0, 7'd35, 0, v_mw);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rs_in_reset", 32'(obs), 32'(v_zero));
    @(posedge clk);
    #1;
`ifdef PERF_COUNTERS_EN
    chk("rs_cycle_cnt", cycle_cnt, 32'd0);
    chk("rs_instret_cnt", instret_cnt, 32'd0);
`endif
    rst = 1'b0;
    step("rs_fetch_after", 1, 7'd51, 0, v_fr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
